// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle CPU main FSM and its datapath.
// master = controller side (drives enables/selects), slave = datapath side (drives IR fields and zero).
interface mc_ctrl_fsm_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               ir_write;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic               ext_op;
    logic [1:0]         alu_op;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, funct, zero,
        output pc_write, pc_src, ir_write, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op, illegal, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_write, pc_src, ir_write, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op, illegal, state
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS-subset CPU: sequences fetch/decode/execute/memory/writeback.
// Outputs are Moore except the BRANCH pc_write, which follows the ALU zero flag combinationally.
module mc_ctrl_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int STATE_W         = 4
) (
    input logic           clk,
    input logic           rst,
    mc_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_EXEC_I = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_HALT   = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    state_t r_state;
    state_t w_next_state;
    logic   r_illegal;

    logic w_is_lw;
    logic w_is_sw;
    logic w_is_r_alu;
    logic w_is_jr;
    logic w_is_beq;
    logic w_is_addi;
    logic w_is_ori;
    logic w_is_j;
    logic w_is_jal;
    logic w_decode_legal;

    // IR is held stable after FETCH, so opcode/funct can steer every later state.
    assign w_is_lw    = (bus.opcode == OP_LW);
    assign w_is_sw    = (bus.opcode == OP_SW);
    assign w_is_r_alu = (bus.opcode == OP_RTYPE) &&
                        ((bus.funct == FN_ADDU) || (bus.funct == FN_SUBU) ||
                         (bus.funct == FN_OR)   || (bus.funct == FN_SLT));
    assign w_is_jr    = (bus.opcode == OP_RTYPE) && (bus.funct == FN_JR);
    assign w_is_beq   = (bus.opcode == OP_BEQ);
    assign w_is_addi  = (bus.opcode == OP_ADDI);
    assign w_is_ori   = (bus.opcode == OP_ORI);
    assign w_is_j     = (bus.opcode == OP_J);
    assign w_is_jal   = (bus.opcode == OP_JAL);

    assign w_decode_legal = w_is_lw | w_is_sw | w_is_r_alu | w_is_jr | w_is_beq |
                            w_is_addi | w_is_ori | w_is_j | w_is_jal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_illegal <= 1'b0;
        end else if ((r_state == S_DECODE) && !w_decode_legal) begin
            r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next_state   = S_FETCH;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.ir_write   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 2'b00;
        bus.mem_to_reg = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.ext_op     = 1'b0;
        bus.alu_op     = 2'b00;

        case (r_state)
            S_FETCH: begin
                bus.ir_write  = 1'b1;
                bus.pc_write  = 1'b1;
                bus.alu_src_b = 2'b01;
                w_next_state  = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the instruction is decoded.
                bus.alu_src_b = 2'b11;
                bus.ext_op    = 1'b1;
                if (w_is_lw || w_is_sw) begin
                    w_next_state = S_MEMADR;
                end else if (w_is_r_alu) begin
                    w_next_state = S_EXEC_R;
                end else if (w_is_jr) begin
                    w_next_state = S_JR;
                end else if (w_is_beq) begin
                    w_next_state = S_BRANCH;
                end else if (w_is_addi || w_is_ori) begin
                    w_next_state = S_EXEC_I;
                end else if (w_is_j) begin
                    w_next_state = S_JUMP;
                end else if (w_is_jal) begin
                    w_next_state = S_JAL;
                end else if (HALT_ON_ILLEGAL) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.ext_op    = 1'b1;
                w_next_state  = w_is_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                w_next_state  = S_RWB;
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 2'b01;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                if (w_is_ori) begin
                    bus.alu_op = 2'b11;
                end else begin
                    bus.ext_op = 1'b1;
                end
                w_next_state = S_IWB;
            end
            S_IWB: begin
                bus.reg_write = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                bus.pc_write  = bus.zero;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b10;
            end
            S_JAL: begin
                // Link value is PC+4, which FETCH already wrote into PC.
                bus.pc_write   = 1'b1;
                bus.pc_src     = 2'b10;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b10;
                bus.mem_to_reg = 2'b10;
            end
            S_JR: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b11;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign bus.illegal = r_illegal;
    assign bus.state   = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed table, randomized instruction stream against a path model,
// and hand-written reset / illegal-instruction sequences.
module tb_mc_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic [31:0] pc;

  int n_checks;
  int n_fail;
  logic exp_ill;
  int exp_path[$];

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         zmode;
    int         cycles;
    int         last;
  } vec_t;

  vec_t tbl[14];

  mc_ctrl_fsm_if #(.STATE_W(4)) bus_h ();
  mc_ctrl_fsm_if #(.STATE_W(4)) bus_n ();

  assign bus_h.opcode = opcode;
  assign bus_h.funct  = funct;
  assign bus_h.zero   = zero;
  assign bus_n.opcode = opcode;
  assign bus_n.funct  = funct;
  assign bus_n.zero   = zero;

  mc_ctrl_fsm #(.HALT_ON_ILLEGAL(1'b1), .STATE_W(4)) dut_h (.clk(clk), .rst(rst_n), .bus(bus_h));
  mc_ctrl_fsm #(.HALT_ON_ILLEGAL(1'b0), .STATE_W(4)) dut_n (.clk(clk), .rst(rst_n), .bus(bus_n));

  logic [15:0] act_ctrl_n;
  logic [15:0] act_ctrl_h;
  assign act_ctrl_n = {bus_n.pc_write, bus_n.pc_src, bus_n.ir_write, bus_n.mem_write,
                       bus_n.reg_write, bus_n.reg_dst, bus_n.mem_to_reg, bus_n.alu_src_a,
                       bus_n.alu_src_b, bus_n.ext_op, bus_n.alu_op};
  assign act_ctrl_h = {bus_h.pc_write, bus_h.pc_src, bus_h.ir_write, bus_h.mem_write,
                       bus_h.reg_write, bus_h.reg_dst, bus_h.mem_to_reg, bus_h.alu_src_a,
                       bus_h.alu_src_b, bus_h.ext_op, bus_h.alu_op};

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external PC register fed by the FETCH increment (ALU result = PC+4)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'h3000;
    else if (bus_n.pc_write && bus_n.pc_src == 2'b00) pc <= pc + 32'd4;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 lw, 1 sw, 2 R-alu, 3 jr, 4 beq, 5 addi, 6 ori, 7 j, 8 jal, 9 illegal
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000000: begin
        if (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b100101 || fn == 6'b101010) return 2;
        if (fn == 6'b001000) return 3;
        return 9;
      end
      6'b000100: return 4;
      6'b001000: return 5;
      6'b001101: return 6;
      6'b000010: return 7;
      6'b000011: return 8;
      default:   return 9;
    endcase
  endfunction

  // state sequence of one instruction in no-halt mode, FETCH first
  function automatic void build_path(input int cls);
    exp_path = '{0, 1};
    case (cls)
      0: begin exp_path.push_back(2); exp_path.push_back(3); exp_path.push_back(4); end
      1: begin exp_path.push_back(2); exp_path.push_back(5); end
      2: begin exp_path.push_back(6); exp_path.push_back(7); end
      3: exp_path.push_back(13);
      4: exp_path.push_back(10);
      5, 6: begin exp_path.push_back(8); exp_path.push_back(9); end
      7: exp_path.push_back(11);
      8: exp_path.push_back(12);
      default: ;
    endcase
  endfunction

  // {pc_write, pc_src, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op}
  function automatic logic [15:0] exp_ctrl(input int st, input logic [5:0] op, input logic z);
    logic pw, irw, mw, rw, asa, ext;
    logic [1:0] ps, rd, m2r, asb, aop;
    {pw, ps, irw, mw, rw, rd, m2r, asa, asb, ext, aop} = '0;
    case (st)
      0:  begin irw = 1; pw = 1; asb = 2'b01; end
      1:  begin asb = 2'b11; ext = 1; end
      2:  begin asa = 1; asb = 2'b10; ext = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  mw = 1;
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin
            asa = 1; asb = 2'b10;
            if (op == 6'b001101) aop = 2'b11;
            else ext = 1;
          end
      9:  rw = 1;
      10: begin asa = 1; aop = 2'b01; ps = 2'b01; pw = z; end
      11: begin pw = 1; ps = 2'b10; end
      12: begin pw = 1; ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      13: begin pw = 1; ps = 2'b11; end
      default: ;
    endcase
    return {pw, ps, irw, mw, rw, rd, m2r, asa, asb, ext, aop};
  endfunction

  // Leaves the bench just after a posedge with both DUTs in FETCH.
  task automatic reset_dut();
    rst_n = 1'b0;
    exp_ill = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(bus_n.state), 32'd0);
    check("rst_ctrl", 32'(act_ctrl_n), 32'(exp_ctrl(0, opcode, zero)));
    check("rst_illegal", 32'(bus_h.illegal), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // driver: run one instruction on the no-halt DUT, checking each cycle against the model
  task automatic run_one(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                         output int cycles, output int last);
    int cls;
    bit done;
    cls = classify(op, fn);
    build_path(cls);
    opcode = op;
    funct  = fn;
    cycles = 0;
    last   = -1;
    done   = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge clk);
      if (k < exp_path.size()) begin
        check("state", 32'(bus_n.state), 32'(exp_path[k]));
        check("ctrl", 32'(act_ctrl_n), 32'(exp_ctrl(exp_path[k], op, zero)));
        if (exp_path[k] == 1 && cls == 9) begin
          check("illegal", 32'(bus_n.illegal), 32'(exp_ill));
          exp_ill = 1'b1;
        end else begin
          check("illegal", 32'(bus_n.illegal), 32'(exp_ill));
        end
      end else begin
        check("path_len", 32'(k), 32'(exp_path.size()));
      end
      last = int'(bus_n.state);
      cycles++;
      @(posedge clk);
      #1;
      if (bus_n.state == 4'd0) done = 1'b1;
    end
    if (!done) check("instr_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int cyc, last, r;
    logic [5:0] op, fn;

    n_checks = 0;
    n_fail   = 0;
    exp_ill  = 1'b0;
    rst_n    = 1'b0;
    opcode   = 6'b100011;
    funct    = 6'd0;
    zero     = 1'b0;

    tbl[0]  = '{6'b100011, 6'b000000, 0, 5, 4};
    tbl[1]  = '{6'b101011, 6'b000000, 0, 4, 5};
    tbl[2]  = '{6'b000000, 6'b100001, 0, 4, 7};
    tbl[3]  = '{6'b000000, 6'b100011, 1, 4, 7};
    tbl[4]  = '{6'b000000, 6'b100101, 0, 4, 7};
    tbl[5]  = '{6'b000000, 6'b101010, 0, 4, 7};
    tbl[6]  = '{6'b000000, 6'b001000, 0, 3, 13};
    tbl[7]  = '{6'b000100, 6'b000000, 1, 3, 10};
    tbl[8]  = '{6'b000100, 6'b000000, 0, 3, 10};
    tbl[9]  = '{6'b001000, 6'b111111, 0, 4, 9};
    tbl[10] = '{6'b001101, 6'b010101, 1, 4, 9};
    tbl[11] = '{6'b000010, 6'b000000, 0, 3, 11};
    tbl[12] = '{6'b000011, 6'b000000, 1, 3, 12};
    tbl[13] = '{6'b000000, 6'b000001, 0, 2, 1};

    // reset values and external PC stepping
    reset_dut();
    @(negedge clk);
    check("pc_after_reset", pc, 32'h3000);
    @(posedge clk);
    #1;
    check("pc_after_fetch", pc, 32'h3004);
    check("state_after_fetch", 32'(bus_n.state), 32'd1);

    // table-driven instruction vectors
    for (int i = 0; i < 14; i++) begin
      reset_dut();
      run_one(tbl[i].op, tbl[i].fn, tbl[i].zmode, cyc, last);
      check($sformatf("cycles[%0d]", i), 32'(cyc), 32'(tbl[i].cycles));
      check($sformatf("last_state[%0d]", i), 32'(last), 32'(tbl[i].last));
    end

    // illegal opcode: halting DUT sticks in HALT, no-halt DUT keeps fetching with illegal set
    reset_dut();
    opcode = 6'b111111;
    funct  = 6'd0;
    @(negedge clk);
    check("ill_fetch", 32'(bus_h.state), 32'd0);
    @(negedge clk);
    check("ill_decode", 32'(bus_h.state), 32'd1);
    check("ill_not_yet", 32'(bus_h.illegal), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("halt_state", 32'(bus_h.state), 32'd14);
      check("halt_illegal", 32'(bus_h.illegal), 32'd1);
      check("halt_ctrl", 32'(act_ctrl_h), 32'd0);
      check("nop_illegal", 32'(bus_n.illegal), 32'd1);
      if (i == 0) check("nop_refetch", 32'(bus_n.state), 32'd0);
    end

    // asynchronous reset while storing: mem_write must drop before the next edge
    reset_dut();
    opcode = 6'b101011;
    funct  = 6'd0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("sw_state", 32'(bus_n.state), 32'd5);
    check("sw_mem_write", 32'(bus_n.mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_mem_write", 32'(bus_n.mem_write), 32'd0);
    check("async_state", 32'(bus_n.state), 32'd0);
    check("async_ctrl", 32'(act_ctrl_n), 32'(exp_ctrl(0, opcode, zero)));
    reset_dut();
    run_one(6'b100011, 6'd0, 0, cyc, last);
    check("restart_cycles", 32'(cyc), 32'd5);

    // randomized instruction stream against the path model
    reset_dut();
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 11);
      fn = 6'($urandom);
      case (r)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin
             op = 6'b000000;
             case ($urandom_range(0, 3))
               0: fn = 6'b100001;
               1: fn = 6'b100011;
               2: fn = 6'b100101;
               default: fn = 6'b101010;
             endcase
           end
        3: begin op = 6'b000000; fn = 6'b001000; end
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'b001101;
        7: op = 6'b000010;
        8: op = 6'b000011;
        9: op = 6'b000000;
        default: op = 6'($urandom);
      endcase
      run_one(op, fn, 2, cyc, last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Main control state machine for the multicycle MIPS-subset CPU.
- Sequences the shared datapath (PC register, IR, register file, single ALU, unified memory) through fetch/decode/execute/memory/writeback steps.
- Drives the PC register's write-enable `control` input and next-PC mux select.
- Moore outputs, except the branch PC write, which also depends on `zero`.

Parameters:
- HALT_ON_ILLEGAL, 1: 1 = unknown opcode/funct enters HALT until reset; 0 = it is treated as a NOP and fetch resumes.
- STATE_W, 4: width of the state register and of the `state` debug port.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in the BRANCH cycle
- pc_write  out  1  drives PC `control`; 1 = PC loads its din at the next clk edge
- pc_src  out  2  next-PC select: 00 ALU result, 01 branch target (ALUOut), 10 jump {PC[31:28],IR[25:0],2'b00}, 11 register A (jr)
- ir_write  out  1  IR load enable
- mem_write  out  1  data memory write
- reg_write  out  1  register file write
- reg_dst  out  2  write address select: 00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  write data select: 00 ALUOut, 01 MDR, 10 PC (link)
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 register B, 01 constant 4, 10 extended imm, 11 extended imm<<2
- ext_op  out  1  1 = sign-extend, 0 = zero-extend
- alu_op  out  2  00 add, 01 sub, 10 decode from funct, 11 or
- illegal  out  1  sticky; set on an undecodable instruction
- state  out  STATE_W  current state, for debug

Behaviour:
- Reset (rst=0, asynchronous):
  - state = FETCH(0), illegal = 0.
  - All outputs take their FETCH values immediately.
- Default output value is 0 in every state unless listed below.
- States, outputs and transitions:
  - FETCH(0): ir_write=1, pc_write=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=00 → DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, ext_op=1, alu_op=00 (branch target precomputed). Next state by opcode:
    - lw 100011 / sw 101011 → MEMADR
    - R-type 000000 with funct in {100001 addu, 100011 subu, 100101 or, 101010 slt} → EXEC_R
    - R-type 000000 with funct 001000 → JR
    - beq 000100 → BRANCH
    - addi 001000 / ori 001101 → EXEC_I
    - j 000010 → JUMP
    - jal 000011 → JAL
    - anything else → ILLEGAL handling (below)
  - MEMADR(2): alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=00 → MEMRD for lw, MEMWR for sw.
  - MEMRD(3): → MEMWB.
  - MEMWB(4): reg_write=1, reg_dst=00, mem_to_reg=01 → FETCH.
  - MEMWR(5): mem_write=1 → FETCH.
  - EXEC_R(6): alu_src_a=1, alu_src_b=00, alu_op=10 → RWB.
  - RWB(7): reg_write=1, reg_dst=01, mem_to_reg=00 → FETCH.
  - EXEC_I(8): alu_src_a=1, alu_src_b=10.
    - addi: ext_op=1, alu_op=00.
    - ori: ext_op=0, alu_op=11.
    - → IWB.
  - IWB(9): reg_write=1, reg_dst=00, mem_to_reg=00 → FETCH.
  - BRANCH(10): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero (combinational) → FETCH.
  - JUMP(11): pc_write=1, pc_src=10 → FETCH.
  - JAL(12): pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10 → FETCH. The link value is PC+4, already in PC from FETCH.
  - JR(13): pc_write=1, pc_src=11 → FETCH.
  - HALT(14): all enables 0; self-loop until reset.
- Illegal instruction (decided in DECODE): set illegal=1 on the DECODE→next edge.
  - HALT_ON_ILLEGAL=1 → HALT.
  - HALT_ON_ILLEGAL=0 → FETCH; illegal stays 1 until reset.
- Unused encodings (15) → FETCH on the next edge, with no output asserted.
- Cycle counts (FETCH through last state inclusive):
  - lw 5
  - sw, R-type, addi, ori 4
  - beq, j, jal, jr 3
- At most one of pc_write / mem_write / reg_write sources is asserted per state, except JAL (pc_write and reg_write together, by design).
- Reset mid-instruction: the partial instruction is abandoned. Any mem_write/reg_write deasserts immediately, and fetch restarts on the first clk edge after rst returns high.

Test Plan:
- Hold rst=0 for 2 cycles, then release → state=0, pc_write=1, ir_write=1, illegal=0; external PC reads 0x3000 then 0x3004 after the first edge.
- opcode=100011 (lw) → state sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=01 only in state 4; pc_write high only in state 0.
- opcode=000100 with zero=1, then with zero=0 → state 10 reached in both cases; pc_write=1 in state 10 only when zero=1; pc_src=01.
- opcode=000011 (jal) → states 0,1,12; in state 12 pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- opcode=111111 with HALT_ON_ILLEGAL=1 → illegal=1, state stuck at 14 for ≥10 cycles; with HALT_ON_ILLEGAL=0 → returns to state 0, illegal stays 1.
- Pull rst low asynchronously while in state 5 (sw) → mem_write drops before the next clk edge; state=0 during reset.
